// File: rtl/apb_ucpd_rx_dec_if.sv
// rtl/apb_ucpd_rx_dec_if.sv - bit-stream input and decode event bundle for the UCPD RX symbol decoder
`timescale 1ns/1ps
interface apb_ucpd_rx_dec_if;
  logic       ucpden;
  logic       receive_en;
  logic       rx_bit_vld;
  logic       rx_bit;
  logic [6:0] ordset_en;
  logic       rx_pre_cmplt;
  logic       rx_sop_cmplt;
  logic [2:0] rx_ordset;
  logic       hrst_vld;
  logic       crst_vld;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       eop_ok;
  logic       rx_err;
  logic       rx_busy;

  modport master (
    output ucpden, receive_en, rx_bit_vld, rx_bit, ordset_en,
    input  rx_pre_cmplt, rx_sop_cmplt, rx_ordset, hrst_vld, crst_vld,
           rx_byte, rx_byte_vld, eop_ok, rx_err, rx_busy
  );

  modport slave (
    input  ucpden, receive_en, rx_bit_vld, rx_bit, ordset_en,
    output rx_pre_cmplt, rx_sop_cmplt, rx_ordset, hrst_vld, crst_vld,
           rx_byte, rx_byte_vld, eop_ok, rx_err, rx_busy
  );
endinterface

// File: rtl/apb_ucpd_rx_dec.sv
// rtl/apb_ucpd_rx_dec.sv - UCPD RX preamble/ordered-set/4b5b decoder; UCPD_RX_ORDSET_3OF4_EN enables 3-of-4 ordered-set match
`timescale 1ns/1ps
module apb_ucpd_rx_dec #(
  parameter int         PRE_MIN_BITS = 16,
  parameter logic [9:0] MAX_BYTES    = 10'd264
) (
  input logic             ic_clk,
  input logic             ic_rst,
  apb_ucpd_rx_dec_if.slave bus
);
  localparam logic [4:0] K_S1  = 5'b11000;
  localparam logic [4:0] K_S2  = 5'b10001;
  localparam logic [4:0] K_S3  = 5'b00110;
  localparam logic [4:0] K_R1  = 5'b00111;
  localparam logic [4:0] K_R2  = 5'b11001;
  localparam logic [4:0] K_EOP = 5'b01101;
  localparam int         PCW     = $clog2(PRE_MIN_BITS + 1);
  localparam logic [PCW-1:0] PRE_TGT = PCW'(PRE_MIN_BITS);

  typedef enum logic [1:0] {IDLE, PRE, SOP, DATA} state_t;

  state_t         state, state_nxt;
  logic [PCW-1:0] pre_cnt, pre_cnt_nxt;
  logic           prev_bit, prev_bit_nxt;
  logic [19:0]    win, win_nxt, win_sh;
  logic [3:0]     bit_cnt, bit_cnt_nxt;
  logic [3:0]     lo_nib, lo_nib_nxt;
  logic [9:0]     byte_cnt, byte_cnt_nxt;
  logic [2:0]     ordset_q, ordset_nxt;
  logic [7:0]     byte_q, byte_nxt;
  logic           pre_p, sop_p, hrst_p, crst_p, bvld_p, eop_p, err_p;
  logic           pre_nxt, sop_nxt, hrst_nxt, crst_nxt, bvld_nxt, eop_nxt, err_nxt;
  logic [6:0]     hit;
  logic [4:0]     sym_dec;

  // Oldest symbol sits in win[4:0]; each symbol's first bit is its LSB.
  function automatic logic set_match(logic [19:0] w, logic [4:0] k0, logic [4:0] k1,
                                     logic [4:0] k2, logic [4:0] k3);
    logic [2:0] hits;
    hits = 3'(w[4:0] == k0) + 3'(w[9:5] == k1) + 3'(w[14:10] == k2) + 3'(w[19:15] == k3);
`ifdef UCPD_RX_ORDSET_3OF4_EN
    return hits >= 3'd3;
`else
    return hits == 3'd4;
`endif
  endfunction

  // Returns {valid, nibble}.
  function automatic logic [4:0] dec5(logic [4:0] s);
    case (s)
      5'b11110: dec5 = 5'h10;  5'b01001: dec5 = 5'h11;
      5'b10100: dec5 = 5'h12;  5'b10101: dec5 = 5'h13;
      5'b01010: dec5 = 5'h14;  5'b01011: dec5 = 5'h15;
      5'b01110: dec5 = 5'h16;  5'b01111: dec5 = 5'h17;
      5'b10010: dec5 = 5'h18;  5'b10011: dec5 = 5'h19;
      5'b10110: dec5 = 5'h1A;  5'b10111: dec5 = 5'h1B;
      5'b11010: dec5 = 5'h1C;  5'b11011: dec5 = 5'h1D;
      5'b11100: dec5 = 5'h1E;  5'b11101: dec5 = 5'h1F;
      default:  dec5 = 5'h00;
    endcase
  endfunction

  assign win_sh  = {bus.rx_bit, win[19:1]};
  assign sym_dec = dec5(win_sh[19:15]);
  assign hit[0]  = bus.ordset_en[0] & set_match(win_sh, K_S1, K_S1, K_S1, K_S2);
  assign hit[1]  = bus.ordset_en[1] & set_match(win_sh, K_S1, K_S1, K_S3, K_S3);
  assign hit[2]  = bus.ordset_en[2] & set_match(win_sh, K_S1, K_S3, K_S1, K_S3);
  assign hit[3]  = bus.ordset_en[3] & set_match(win_sh, K_R1, K_R1, K_R1, K_R2);
  assign hit[4]  = bus.ordset_en[4] & set_match(win_sh, K_R1, K_S1, K_R1, K_S3);
  assign hit[5]  = bus.ordset_en[5] & set_match(win_sh, K_S1, K_R2, K_R2, K_S3);
  assign hit[6]  = bus.ordset_en[6] & set_match(win_sh, K_S1, K_R2, K_S3, K_S2);

  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pre_cnt_nxt  = pre_cnt;
    prev_bit_nxt = prev_bit;
    win_nxt      = win;
    bit_cnt_nxt  = bit_cnt;
    lo_nib_nxt   = lo_nib;
    byte_cnt_nxt = byte_cnt;
    ordset_nxt   = ordset_q;
    byte_nxt     = byte_q;
    pre_nxt      = 1'b0;
    sop_nxt      = 1'b0;
    hrst_nxt     = 1'b0;
    crst_nxt     = 1'b0;
    bvld_nxt     = 1'b0;
    eop_nxt      = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        pre_cnt_nxt  = '0;
        prev_bit_nxt = 1'b0;
        win_nxt      = '0;
        bit_cnt_nxt  = '0;
        byte_cnt_nxt = '0;
        state_nxt    = PRE;
      end
      PRE: if (bus.rx_bit_vld) begin
        prev_bit_nxt = bus.rx_bit;
        if (bus.rx_bit != prev_bit)
          pre_cnt_nxt = (pre_cnt == PRE_TGT) ? pre_cnt : pre_cnt + PCW'(1);
        else
          pre_cnt_nxt = PCW'(1);
        if (pre_cnt_nxt == PRE_TGT) begin
          pre_nxt   = 1'b1;
          state_nxt = SOP;
        end
      end
      SOP: if (bus.rx_bit_vld) begin
        win_nxt = win_sh;
        if (hit[3]) begin
          hrst_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (hit[4]) begin
          crst_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (|{hit[6:5], hit[2:0]}) begin
          sop_nxt      = 1'b1;
          state_nxt    = DATA;
          bit_cnt_nxt  = '0;
          byte_cnt_nxt = '0;
          if (hit[0])      ordset_nxt = 3'd0;
          else if (hit[1]) ordset_nxt = 3'd1;
          else if (hit[2]) ordset_nxt = 3'd2;
          else if (hit[5]) ordset_nxt = 3'd5;
          else             ordset_nxt = 3'd6;
        end
      end
      DATA: if (bus.rx_bit_vld) begin
        win_nxt     = win_sh;
        bit_cnt_nxt = bit_cnt + 4'd1;
        if (bit_cnt == 4'd4) begin
          if (sym_dec[4]) begin
            lo_nib_nxt = sym_dec[3:0];
          end else begin
            // EOP is only clean between bytes and after at least one byte.
            if (win_sh[19:15] == K_EOP && byte_cnt != 10'd0) eop_nxt = 1'b1;
            else                                            err_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end else if (bit_cnt == 4'd9) begin
          bit_cnt_nxt = '0;
          if (!sym_dec[4] || byte_cnt == MAX_BYTES) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            byte_nxt     = {sym_dec[3:0], lo_nib};
            bvld_nxt     = 1'b1;
            byte_cnt_nxt = byte_cnt + 10'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!bus.ucpden || !bus.receive_en) begin
      state_nxt  = IDLE;
      ordset_nxt = ordset_q;
      byte_nxt   = byte_q;
      pre_nxt    = 1'b0;
      sop_nxt    = 1'b0;
      hrst_nxt   = 1'b0;
      crst_nxt   = 1'b0;
      bvld_nxt   = 1'b0;
      eop_nxt    = 1'b0;
      err_nxt    = 1'b0;
    end
  end

  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) begin
      pre_cnt  <= '0;
      prev_bit <= 1'b0;
      win      <= '0;
      bit_cnt  <= '0;
      lo_nib   <= '0;
      byte_cnt <= '0;
      ordset_q <= '0;
      byte_q   <= '0;
      pre_p    <= 1'b0;
      sop_p    <= 1'b0;
      hrst_p   <= 1'b0;
      crst_p   <= 1'b0;
      bvld_p   <= 1'b0;
      eop_p    <= 1'b0;
      err_p    <= 1'b0;
    end else begin
      pre_cnt  <= pre_cnt_nxt;
      prev_bit <= prev_bit_nxt;
      win      <= win_nxt;
      bit_cnt  <= bit_cnt_nxt;
      lo_nib   <= lo_nib_nxt;
      byte_cnt <= byte_cnt_nxt;
      ordset_q <= ordset_nxt;
      byte_q   <= byte_nxt;
      pre_p    <= pre_nxt;
      sop_p    <= sop_nxt;
      hrst_p   <= hrst_nxt;
      crst_p   <= crst_nxt;
      bvld_p   <= bvld_nxt;
      eop_p    <= eop_nxt;
      err_p    <= err_nxt;
    end
  end

  assign bus.rx_pre_cmplt = pre_p;
  assign bus.rx_sop_cmplt = sop_p;
  assign bus.rx_ordset    = ordset_q;
  assign bus.hrst_vld     = hrst_p;
  assign bus.crst_vld     = crst_p;
  assign bus.rx_byte      = byte_q;
  assign bus.rx_byte_vld  = bvld_p;
  assign bus.eop_ok       = eop_p;
  assign bus.rx_err       = err_p;
  assign bus.rx_busy      = (state == SOP) || (state == DATA);
endmodule

// File: tb/tb_apb_ucpd_rx_dec.sv
// tb/tb_apb_ucpd_rx_dec.sv - self-checking bench for apb_ucpd_rx_dec
`timescale 1ns/1ps
module tb_apb_ucpd_rx_dec;
  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOPK = 5'b01101, BAD = 5'b00000;

  typedef struct {
    logic [4:0] lo_sym;
    logic [4:0] hi_sym;
    logic [7:0] exp_byte;
  } vec_t;

  logic ic_clk = 1'b0;
  logic ic_rst;
  always #5 ic_clk = ~ic_clk;

  apb_ucpd_rx_dec_if u_if();
  apb_ucpd_rx_dec dut (.ic_clk(ic_clk), .ic_rst(ic_rst), .bus(u_if.slave));

  int checks = 0, errors = 0;
  int n_pre, n_sop, n_hrst, n_crst, n_eop, n_err, n_byte;
  int strobes, pre_at, sop_at, err_at;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [4:0] d5[16];
  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  always @(negedge ic_clk) if (!ic_rst) begin
    if (u_if.rx_pre_cmplt) begin n_pre++; pre_at = strobes; end
    if (u_if.rx_sop_cmplt) begin n_sop++; sop_at = strobes; end
    if (u_if.hrst_vld) n_hrst++;
    if (u_if.crst_vld) n_crst++;
    if (u_if.eop_ok) n_eop++;
    if (u_if.rx_err) begin n_err++; err_at = strobes; end
    if (u_if.rx_byte_vld) begin
      n_byte++;
      if (exp_q.size() == 0) chk("byte_unexpected", int'(u_if.rx_byte), -1);
      else begin
        exp_b = exp_q.pop_front();
        chk("rx_byte", int'(u_if.rx_byte), int'(exp_b));
      end
    end
    if (u_if.rx_bit_vld) strobes++;
  end

  task automatic send_bit(input logic b);
    @(posedge ic_clk); #1;
    u_if.rx_bit_vld = 1'b1;
    u_if.rx_bit     = b;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge ic_clk); #1;
      u_if.rx_bit_vld = 1'b0;
    end
  endtask

  task automatic send_sym(input logic [4:0] s);
    for (int i = 0; i < 5; i++) send_bit(s[i]);
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) send_bit(i[0]);
  endtask

  task automatic send_os(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    send_sym(a); send_sym(b); send_sym(c); send_sym(d);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push);
    if (push) exp_q.push_back(b);
    send_sym(d5[b[3:0]]);
    send_sym(d5[b[7:4]]);
  endtask

  task automatic begin_test();
    gap(4);
    n_pre = 0; n_sop = 0; n_hrst = 0; n_crst = 0; n_eop = 0; n_err = 0; n_byte = 0;
    strobes = 0; pre_at = -1; sop_at = -1; err_at = -1;
    exp_q.delete();
  endtask

  task automatic end_test();
    gap(4);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic drop_rx();
    @(posedge ic_clk); #1;
    u_if.rx_bit_vld = 1'b0;
    u_if.receive_en = 1'b0;
    gap(1);
    chk("busy_after_drop", int'(u_if.rx_busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    d5 = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
           5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};
    vecs[0] = '{5'b01001, 5'b10110, 8'hA1};
    vecs[1] = '{5'b11101, 5'b01011, 8'h5F};
    vecs[2] = '{5'b11110, 5'b10100, 8'h20};
    vecs[3] = '{5'b10101, 5'b01010, 8'h43};
    vecs[4] = '{5'b01110, 5'b01111, 8'h76};
    vecs[5] = '{5'b10010, 5'b10011, 8'h98};
    vecs[6] = '{5'b10111, 5'b11010, 8'hCB};
    vecs[7] = '{5'b11011, 5'b11100, 8'hED};

    ic_rst = 1'b1;
    u_if.ucpden = 1'b1; u_if.receive_en = 1'b1; u_if.ordset_en = 7'h7F;
    u_if.rx_bit_vld = 1'b0; u_if.rx_bit = 1'b0;
    send_pre(6);
    @(negedge ic_clk);
    chk("rst_busy", int'(u_if.rx_busy), 0);
    chk("rst_pulses", int'({u_if.rx_pre_cmplt, u_if.rx_sop_cmplt, u_if.hrst_vld, u_if.crst_vld,
                            u_if.rx_byte_vld, u_if.eop_ok, u_if.rx_err}), 0);
    chk("rst_rx_byte", int'(u_if.rx_byte), 0);
    chk("rst_rx_ordset", int'(u_if.rx_ordset), 0);
    @(posedge ic_clk); #1;
    u_if.rx_bit_vld = 1'b0;
    ic_rst = 1'b0;

    // Full packet driven from the vector table
    begin_test();
    send_pre(64);
    send_os(S1, S1, S1, S2);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp_byte);
      send_sym(vecs[i].lo_sym);
      send_sym(vecs[i].hi_sym);
      if (i[0]) gap(2);
    end
    send_sym(EOPK);
    end_test();
    chk("pkt_pre_cnt", n_pre, 1);
    chk("pkt_pre_at", pre_at, 16);
    chk("pkt_sop_cnt", n_sop, 1);
    chk("pkt_sop_at", sop_at, 84);
    chk("pkt_ordset", int'(u_if.rx_ordset), 0);
    chk("pkt_bytes", n_byte, 8);
    chk("pkt_eop", n_eop, 1);
    chk("pkt_err", n_err, 0);
    chk("pkt_busy_end", int'(u_if.rx_busy), 0);

    // SOP' followed immediately by EOP: zero-byte packet is an error
    begin_test();
    send_pre(64);
    send_os(S1, S1, S3, S3);
    send_sym(EOPK);
    end_test();
    chk("sop1_ordset", int'(u_if.rx_ordset), 1);
    chk("sop1_err", n_err, 1);
    chk("sop1_eop", n_eop, 0);

    // Hard Reset
    begin_test();
    send_pre(64);
    send_os(R1, R1, R1, R2);
    end_test();
    chk("hr_hrst", n_hrst, 1);
    chk("hr_sop", n_sop, 0);
    chk("hr_busy", int'(u_if.rx_busy), 0);
    chk("hr_ordset_kept", int'(u_if.rx_ordset), 1);

    // Hard Reset disabled: decoder keeps hunting
    u_if.ordset_en = 7'h77;
    begin_test();
    send_pre(64);
    send_os(R1, R1, R1, R2);
    gap(4);
    chk("hr_dis_hrst", n_hrst, 0);
    chk("hr_dis_busy", int'(u_if.rx_busy), 1);
    drop_rx();
    u_if.receive_en = 1'b1;
    u_if.ordset_en = 7'h7F;

    // Cable Reset
    begin_test();
    send_pre(64);
    send_os(R1, S1, R1, S3);
    end_test();
    chk("cr_crst", n_crst, 1);
    chk("cr_hrst", n_hrst, 0);
    chk("cr_busy", int'(u_if.rx_busy), 0);

    // Invalid data symbol, then a clean SOP'' packet
    begin_test();
    send_pre(64);
    send_os(S1, S1, S1, S2);
    send_sym(BAD);
    end_test();
    chk("bad_err", n_err, 1);
    chk("bad_err_at", err_at, 89);
    chk("bad_bytes", n_byte, 0);
    begin_test();
    send_pre(64);
    send_os(S1, S3, S1, S3);
    send_byte(8'h5A, 1'b1);
    send_sym(EOPK);
    end_test();
    chk("rec_ordset", int'(u_if.rx_ordset), 2);
    chk("rec_bytes", n_byte, 1);
    chk("rec_eop", n_eop, 1);
    chk("rec_err", n_err, 0);

    // SOP'_Debug, one byte, then EOP on a half-byte boundary
    begin_test();
    send_pre(64);
    send_os(S1, R2, R2, S3);
    send_byte(8'h3C, 1'b1);
    send_sym(d5[7]);
    send_sym(EOPK);
    end_test();
    chk("half_ordset", int'(u_if.rx_ordset), 5);
    chk("half_err", n_err, 1);
    chk("half_eop", n_eop, 0);

    // SOP''_Debug disabled never matches
    u_if.ordset_en = 7'h3F;
    begin_test();
    send_pre(64);
    send_os(S1, R2, S3, S2);
    gap(4);
    chk("dbg_dis_sop", n_sop, 0);
    drop_rx();
    u_if.receive_en = 1'b1;
    u_if.ordset_en = 7'h7F;

    // Corrupted SOP (one symbol wrong)
    begin_test();
    send_pre(64);
    send_os(S1, S1, S2, S2);
    gap(4);
`ifdef UCPD_RX_ORDSET_3OF4_EN
    chk("corrupt_sop", n_sop, 1);
    chk("corrupt_ordset", int'(u_if.rx_ordset), 0);
`else
    chk("corrupt_sop", n_sop, 0);
    chk("corrupt_busy", int'(u_if.rx_busy), 1);
`endif
    drop_rx();
    u_if.receive_en = 1'b1;

    // receive_en dropped after half a byte
    begin_test();
    send_pre(64);
    send_os(S1, S1, S1, S2);
    send_byte(8'h96, 1'b1);
    send_sym(d5[1]);
    gap(1);
    chk("drop_busy_before", int'(u_if.rx_busy), 1);
    drop_rx();
    send_sym(d5[2]);
    gap(2);
    u_if.receive_en = 1'b1;
    end_test();
    chk("drop_bytes", n_byte, 1);
    chk("drop_err", n_err, 0);
    chk("drop_eop", n_eop, 0);

    // Exactly MAX_BYTES then EOP
    begin_test();
    send_pre(64);
    send_os(S1, S1, S1, S2);
    for (int i = 0; i < 264; i++) send_byte(8'(i * 7 + 3), 1'b1);
    send_sym(EOPK);
    end_test();
    chk("max_bytes", n_byte, 264);
    chk("max_eop", n_eop, 1);
    chk("max_err", n_err, 0);

    // One byte beyond MAX_BYTES
    begin_test();
    send_pre(64);
    send_os(S1, S1, S1, S2);
    for (int i = 0; i < 265; i++) send_byte(8'(i * 5), i < 264);
    end_test();
    chk("ovf_bytes", n_byte, 264);
    chk("ovf_err", n_err, 1);
    chk("ovf_err_at", err_at, 84 + 2650);
    chk("ovf_eop", n_eop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_ucpd_rx_dec.md
Name: apb_ucpd_rx_dec

Overview:
- Receive-side symbol decoder for the UCPD PHY; the receive counterpart of the TX framing path (preamble / SOP / 4b5b data / CRC / EOP).
- Consumes BMC-decoded bits, qualifies the preamble and hunts for a K-code ordered set.
- Decodes 5b symbols into bytes and detects EOP, Hard Reset and Cable Reset.
- Drives rx_pre_cmplt, rx_sop_cmplt, eop_ok, hrst_vld and crst_vld into the main PD FSM, and bytes into the RX FIFO / RXDR logic.

Parameters:
- PRE_MIN_BITS, 16: minimum count of consecutive alternating bits before ordered-set hunting starts.
- MAX_BYTES, 10'd264: payload-byte limit per packet, CRC included; exceeding it is an error.

Ports:
- ic_clk  in  1  HSI16 kernel clock; all logic on rising edge.
- ic_rst  in  1  asynchronous, active-high reset.
- ucpden  in  1  peripheral enable; low forces IDLE synchronously.
- receive_en  in  1  RX enabled by the main FSM; low forces IDLE.
- rx_bit_vld  in  1  one-cycle strobe qualifying rx_bit.
- rx_bit  in  1  BMC-decoded line bit.
- ordset_en  in  7  per-ordered-set enable: [0] SOP, [1] SOP', [2] SOP'', [3] Hard Reset, [4] Cable Reset, [5] SOP'_Debug, [6] SOP''_Debug.
- rx_pre_cmplt  out  1  pulse: preamble qualified.
- rx_sop_cmplt  out  1  pulse: enabled SOP-class ordered set accepted.
- rx_ordset  out  3  index of the accepted ordered set (0..6, bit numbering of ordset_en); held until next acceptance.
- hrst_vld  out  1  pulse: Hard Reset accepted.
- crst_vld  out  1  pulse: Cable Reset accepted.
- rx_byte  out  8  decoded byte; valid with rx_byte_vld.
- rx_byte_vld  out  1  pulse per decoded byte.
- eop_ok  out  1  pulse: EOP on a byte boundary with at least 1 byte received.
- rx_err  out  1  pulse: invalid symbol, EOP on a half-byte boundary, or MAX_BYTES overflow.
- rx_busy  out  1  high in the SOP and DATA states.

Behaviour:
- Symbol bit order: first received bit goes to bit0 of a 5-bit symbol.
- K-codes: Sync-1 5'b11000, Sync-2 5'b10001, Sync-3 5'b00110, RST-1 5'b00111, RST-2 5'b11001, EOP 5'b01101.
- Data codes, 0x0..0xF: 11110, 01001, 10100, 10101, 01010, 01011, 01110, 01111, 10010, 10011, 10110, 10111, 11010, 11011, 11100, 11101. Any other 5-bit value is invalid.
- Ordered sets, listed first-received symbol first:
  - SOP = S1 S1 S1 S2
  - SOP' = S1 S1 S3 S3
  - SOP'' = S1 S3 S1 S3
  - Hard Reset = R1 R1 R1 R2
  - Cable Reset = R1 S1 R1 S3
  - SOP'_Debug = S1 R2 R2 S3
  - SOP''_Debug = S1 R2 S3 S2
- Reset: all outputs 0, state IDLE, all counters and the 20-bit shift register cleared.
- FSM states and transitions:
  - IDLE: when ucpden and receive_en are both high, go to PRE; the alternating-bit counter is cleared.
  - PRE: on each strobe, the counter increments if rx_bit differs from the previous bit, otherwise it reloads to 1. When the counter reaches PRE_MIN_BITS, pulse rx_pre_cmplt one cycle later and go to SOP. The counter saturates.
  - SOP: each strobe shifts rx_bit into a 20-bit window, and the window is compared against the enabled ordered sets.
    - SOP-class match: pulse rx_sop_cmplt, latch rx_ordset, go to DATA; the bit counter is cleared.
    - Hard Reset or Cable Reset match: pulse hrst_vld or crst_vld, go to IDLE.
    - A disabled ordered set never matches.
    - If several sets match in the same cycle, priority is Hard Reset > Cable Reset > lowest index.
  - DATA: symbols complete every 5 strobes.
    - First symbol of a pair: data code gives the low nibble.
    - Second symbol: data code gives the high nibble; pulse rx_byte_vld one cycle after the 10th bit strobe.
    - EOP as the first symbol with byte count ≥ 1: pulse eop_ok, go to IDLE.
    - EOP as the second symbol, or with byte count 0: pulse rx_err, go to IDLE.
    - Invalid symbol: pulse rx_err, go to IDLE, no rx_byte_vld.
    - A byte that would exceed MAX_BYTES: pulse rx_err, go to IDLE.
- Latency: every pulse output asserts in the cycle after the rx_bit_vld strobe that completes its condition.
- receive_en or ucpden low in any state: IDLE on the next clock, no pulses issued. A partial byte is discarded.
- rx_bit_vld held high on consecutive cycles is legal: each cycle counts as one bit.
- rx_ordset is not modified by Hard Reset or Cable Reset acceptance.

Optional Feature:
- Macro UCPD_RX_ORDSET_3OF4_EN.
- Defined: an ordered set matches when at least 3 of its 4 symbols equal the expected K-codes, in their positions. This is the USB-PD tolerant detection.
- Undefined: all 4 symbols must match exactly.

Test Plan:
- 64-bit alternating preamble, SOP (S1 S1 S1 S2), bytes 0xA1 then 0x5F, EOP, with ordset_en=7'h7F:
  - rx_pre_cmplt after the 16th alternating bit;
  - rx_sop_cmplt with rx_ordset=0;
  - rx_byte 0xA1 then 0x5F, two rx_byte_vld pulses;
  - one eop_ok pulse; no rx_err.
- Preamble then R1 R1 R1 R2 -> one hrst_vld pulse, state IDLE, no rx_sop_cmplt.
- Re-run the previous case with ordset_en[3]=0 -> hrst_vld never asserts and the FSM stays in SOP.
- SOP followed by invalid data symbol 5'b00000 -> one rx_err pulse, no rx_byte_vld, next packet decodes correctly.
- SOP-corrupted (S1 S1 S2 S2) -> with UCPD_RX_ORDSET_3OF4_EN: rx_sop_cmplt with rx_ordset=0; without it: no acceptance.
- receive_en dropped mid-DATA after 5 bits of a byte -> IDLE next cycle, no rx_byte_vld; and 265 bytes after SOP with MAX_BYTES=264 -> rx_err on the 265th byte.
